// File: rtl/cs_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : cs_decode_if
// Description : CPU-side bus bundle for the chip-select decoder.
//               master : drives address, write strobe, bus-active, ROM map
//                        select; receives the device selects and status.
//               slave  : the decoder itself.
// Ports       : MotherboardROMEN, A[23:8], nWE, BACT              (to decoder)
//               RAMCS, ROMCS, IOCS, SCSICS, IACS, IOPWCS,
//               SndRAMCSWR, ROMRDY, Overlay                       (from decoder)
// Revision    : 1.0 - initial release
// ============================================================================
interface cs_decode_if;
    logic        MotherboardROMEN;
    logic [23:8] A;
    logic        nWE;
    logic        BACT;

    logic        RAMCS;
    logic        ROMCS;
    logic        IOCS;
    logic        SCSICS;
    logic        IACS;
    logic        IOPWCS;
    logic        SndRAMCSWR;
    logic        ROMRDY;
    logic        Overlay;

    modport master (
        output MotherboardROMEN, A, nWE, BACT,
        input  RAMCS, ROMCS, IOCS, SCSICS, IACS, IOPWCS, SndRAMCSWR,
               ROMRDY, Overlay
    );

    modport slave (
        input  MotherboardROMEN, A, nWE, BACT,
        output RAMCS, ROMCS, IOCS, SCSICS, IACS, IOPWCS, SndRAMCSWR,
               ROMRDY, Overlay
    );
endinterface
`default_nettype wire

// File: rtl/cs_decode.sv
`default_nettype none
// ============================================================================
// Module      : cs_decode
// Description : Address decoder producing registered device chip selects.
//               Selects are captured at the start of each bus cycle (BACT
//               rising) and held until BACT drops. A boot overlay maps ROM
//               at address 0 until the disable segment is touched. ROM
//               accesses get a programmable wait before ROMRDY.
//               Optional build macro CS_SNOOP_EN enables the video/sound
//               RAM write-snoop selects; without it SndRAMCSWR is 0.
// Ports       : CLK  - clock, all state on rising edge
//               RES  - synchronous active-high reset
//               bus  - cs_decode_if.slave (A, nWE, BACT, MotherboardROMEN in;
//                      selects, ROMRDY, Overlay out)
// Parameters  : RAM_BITS (20..22), OVL_HI, ODIS_SEG, ROM_WS (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module cs_decode #(
    parameter int          RAM_BITS = 22,
    parameter logic [2:0]  OVL_HI   = 3'b011,
    parameter logic [3:0]  ODIS_SEG = 4'h4,
    parameter int          ROM_WS   = 2
) (
    input  wire logic       CLK,
    input  wire logic       RES,
    cs_decode_if.slave      bus
);

    // Byte-address masks over a 24-bit space; only bits [23:8] are visible.
    localparam logic [23:0] C_RAM_SPAN    = (24'd1 << RAM_BITS) - 24'd1;
    localparam logic [23:0] C_RAM_HI_MASK = ~C_RAM_SPAN;
    // Bits [20:RAM_BITS]; empty (all zero) when RAM_BITS >= 21.
    localparam logic [23:0] C_OVL_LO_MASK = C_RAM_HI_MASK & 24'h1F_FFFF;
    localparam logic [3:0]  C_ROM_WS      = 4'(ROM_WS);

    typedef enum logic [1:0] {
        OVL  = 2'd0,
        PEND = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_bact_d;
    logic [6:0]  r_sel;       // {RAM, ROM, IO, SCSI, IA, IOPW, SND}
    logic [3:0]  r_cnt;

    logic        w_ovl;
    logic [3:0]  w_seg;
    logic        w_latch;
    logic        w_ram_raw;
    logic        w_rom_raw;
    logic        w_io_raw;
    logic        w_iopw_raw;
    logic        w_video;
    logic        w_snd;
    logic [6:0]  w_sel_raw;

    assign w_ovl   = (r_state != NORM);
    assign w_seg   = bus.A[23:20];
    assign w_latch = bus.BACT & ~r_bact_d;

    // ---------------------------------------------------------------- decode
    assign w_ram_raw = w_ovl
        ? ((bus.A[23:21] == OVL_HI) && ((bus.A & C_OVL_LO_MASK[23:8]) == 16'h0))
        : ((bus.A & C_RAM_HI_MASK[23:8]) == 16'h0);

    assign w_rom_raw = ((w_seg == 4'h4) && !bus.MotherboardROMEN)
                     || ((w_seg == 4'h8) && bus.MotherboardROMEN)
                     || ((w_seg == 4'h0) && w_ovl);

    // IOPWCS ignores the overlay: it always looks at the unaliased RAM range.
    assign w_iopw_raw = ((bus.A & C_RAM_HI_MASK[23:8]) == 16'h0) && !bus.nWE;

`ifdef CS_SNOOP_EN
    // Top 64 KB of RAM: writes there are also seen by video / sound hardware.
    localparam logic [23:0] C_WIN_MASK = C_RAM_SPAN & 24'hFF_0000;

    logic       w_win;
    logic [3:0] w_nib3;
    logic [3:0] w_nib2;

    assign w_nib3  = bus.A[15:12];
    assign w_nib2  = bus.A[11:8];
    assign w_win   = w_ram_raw && !bus.nWE
                   && ((bus.A & C_WIN_MASK[23:8]) == C_WIN_MASK[23:8]);
    // Video pages: every nibble except 0, 1, 8, 9, i.e. bit2 or bit1 set.
    assign w_video = w_win && (w_nib3[2] || w_nib3[1]);
    assign w_snd   = w_win
        && (((w_nib3 == 4'hF) && (w_nib2 >= 4'hD))
         || ((w_nib3 == 4'hA) && (w_nib2 >= 4'h1) && (w_nib2 <= 4'h3)));
`else
    assign w_video = 1'b0;
    assign w_snd   = 1'b0;
`endif

    assign w_io_raw = ((w_seg == 4'h4) && bus.MotherboardROMEN)
                    || (w_seg == 4'h5) || (w_seg >= 4'h8) || w_video;

    assign w_sel_raw = {w_ram_raw, w_rom_raw, w_io_raw, (w_seg == 4'h5),
                        (bus.A == 16'hFFFF), w_iopw_raw, w_snd};

    // ------------------------------------------------- select / wait counter
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_bact_d <= 1'b0;
            r_sel    <= 7'd0;
            r_cnt    <= 4'd0;
        end else begin
            r_bact_d <= bus.BACT;
            if (!bus.BACT) begin
                r_sel <= 7'd0;
                r_cnt <= 4'd0;
            end else if (w_latch) begin
                r_sel <= w_sel_raw;
                r_cnt <= w_rom_raw ? C_ROM_WS : 4'd0;
            end else if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------ overlay FSM
    always_ff @(posedge CLK) begin
        if (RES) r_state <= OVL;
        else     r_state <= w_state_nxt;
    end

    // PEND keeps the overlay on until the disabling bus cycle has ended, so
    // the decode never changes underneath an active cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OVL:     if (bus.BACT && (w_seg == ODIS_SEG)) w_state_nxt = PEND;
            PEND:    if (!bus.BACT) w_state_nxt = NORM;
            NORM:    w_state_nxt = NORM;
            default: w_state_nxt = OVL;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    assign bus.RAMCS      = r_sel[6];
    assign bus.ROMCS      = r_sel[5];
    assign bus.IOCS       = r_sel[4];
    assign bus.SCSICS     = r_sel[3];
    assign bus.IACS       = r_sel[2];
    assign bus.IOPWCS     = r_sel[1];
    assign bus.SndRAMCSWR = r_sel[0];
    assign bus.ROMRDY     = r_sel[5] && (r_cnt == 4'd0);
    assign bus.Overlay    = w_ovl;

endmodule
`default_nettype wire

// File: tb/tb_cs_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_cs_decode
// Description : Self-checking bench for cs_decode. Drives a default instance
//               (RAM_BITS=22, ROM_WS=2) and a RAM_BITS=21, ROM_WS=0 instance
//               with the same bus stimulus. Select vectors are ordered
//               {RAMCS, ROMCS, IOCS, SCSICS, IACS, IOPWCS, SndRAMCSWR}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_decode;

`ifdef CS_SNOOP_EN
    localparam logic SN = 1'b1;
`else
    localparam logic SN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES;
    logic        mromen;
    logic [15:0] a;
    logic        nwe;
    logic        bact;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    cs_decode_if bus ();
    cs_decode_if bus21 ();

    assign bus.MotherboardROMEN   = mromen;
    assign bus.A                  = a;
    assign bus.nWE                = nwe;
    assign bus.BACT               = bact;
    assign bus21.MotherboardROMEN = mromen;
    assign bus21.A                = a;
    assign bus21.nWE              = nwe;
    assign bus21.BACT             = bact;

    cs_decode u_dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus.slave)
    );

    cs_decode #(.RAM_BITS(21), .ROM_WS(0)) u_dut21 (
        .CLK (CLK),
        .RES (RES),
        .bus (bus21.slave)
    );

    wire [6:0] w_sel   = {bus.RAMCS, bus.ROMCS, bus.IOCS, bus.SCSICS,
                          bus.IACS, bus.IOPWCS, bus.SndRAMCSWR};
    wire [6:0] w_sel21 = {bus21.RAMCS, bus21.ROMCS, bus21.IOCS, bus21.SCSICS,
                          bus21.IACS, bus21.IOPWCS, bus21.SndRAMCSWR};

    typedef struct {
        logic        mromen;
        logic [15:0] a;
        logic        nwe;
        logic [6:0]  exp_sel;
        logic        exp_ovl;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One idle edge (BACT low) followed by the latching edge of a new cycle.
    task automatic run_cycle(input logic m, input logic [15:0] addr, input logic w);
        bact = 1'b0;
        step();
        mromen = m;
        a      = addr;
        nwe    = w;
        bact   = 1'b1;
        step();
    endtask

    initial begin
        vt[0]  = '{1'b0, 16'h0000, 1'b1, 7'b0100000, 1'b1};
        vt[1]  = '{1'b0, 16'h6000, 1'b1, 7'b1000000, 1'b1};
        vt[2]  = '{1'b0, 16'h0012, 1'b0, 7'b0100010, 1'b1};
        vt[3]  = '{1'b1, 16'h8000, 1'b1, 7'b0110000, 1'b1};
        vt[4]  = '{1'b0, 16'h4000, 1'b1, 7'b0100000, 1'b1};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 7'b1000000, 1'b0};
        vt[6]  = '{1'b1, 16'h4000, 1'b1, 7'b0010000, 1'b0};
        vt[7]  = '{1'b0, 16'h5000, 1'b1, 7'b0011000, 1'b0};
        vt[8]  = '{1'b0, 16'hFFFF, 1'b1, 7'b0010100, 1'b0};
        vt[9]  = '{1'b0, 16'h3FFD, 1'b0, {1'b1, 1'b0, SN, 1'b0, 1'b0, 1'b1, SN}, 1'b0};
        vt[10] = '{1'b0, 16'h3F80, 1'b0, 7'b1000010, 1'b0};
        vt[11] = '{1'b0, 16'h3FA2, 1'b0, {1'b1, 1'b0, SN, 1'b0, 1'b0, 1'b1, SN}, 1'b0};
        vt[12] = '{1'b0, 16'h3EFD, 1'b0, 7'b1000010, 1'b0};
        vt[13] = '{1'b0, 16'h3FFD, 1'b1, 7'b1000000, 1'b0};
        vt[14] = '{1'b0, 16'hE000, 1'b1, 7'b0010000, 1'b0};
        vt[15] = '{1'b0, 16'h6000, 1'b1, 7'b0000000, 1'b0};
        vt[16] = '{1'b0, 16'h3FFC, 1'b0, {1'b1, 1'b0, SN, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0};

        // ---- reset state, then boot ROM read at 000000 latched right after reset
        RES = 1'b1; bact = 1'b0; a = 16'h0000; nwe = 1'b1; mromen = 1'b0;
        step();
        step();
        chk("reset_sel",     w_sel, 7'd0);
        chk("reset_sel21",   w_sel21, 7'd0);
        chk("reset_rdy_ovl", {5'd0, bus.ROMRDY, bus.Overlay}, 7'b0000001);

        RES = 1'b0; bact = 1'b1;
        step();
        chk("boot_sel",      w_sel, 7'b0100000);
        chk("boot_rdy_ovl",  {5'd0, bus.ROMRDY, bus.Overlay}, 7'b0000001);
        chk("boot_rdy21_ws0", {6'd0, bus21.ROMRDY}, 7'd1);
        step();
        chk("boot_rdy_wait1", {6'd0, bus.ROMRDY}, 7'd0);
        step();
        chk("boot_rdy_wait2", {6'd0, bus.ROMRDY}, 7'd1);
        a = 16'hE000;
        step();
        chk("boot_rdy_hold",  {6'd0, bus.ROMRDY}, 7'd1);
        bact = 1'b0;
        step();
        chk("boot_end_sel",   w_sel, 7'd0);
        chk("boot_end_rdy",   {6'd0, bus.ROMRDY}, 7'd0);

        // ---- table: back-to-back cycles, one idle edge between each
        for (int i = 0; i < 17; i++) begin
            bact = 1'b0;
            step();
            chk($sformatf("vec%0d_idle", i), w_sel, 7'd0);
            mromen = vt[i].mromen;
            a      = vt[i].a;
            nwe    = vt[i].nwe;
            bact   = 1'b1;
            step();
            chk($sformatf("vec%0d_sel", i), w_sel, vt[i].exp_sel);
            chk($sformatf("vec%0d_ovl", i), {6'd0, bus.Overlay}, {6'd0, vt[i].exp_ovl});
        end

        // ---- address / strobe change mid-cycle must not disturb the selects
        run_cycle(1'b0, 16'h0000, 1'b1);
        chk("hold_start", w_sel, 7'b1000000);
        a = 16'hE000; nwe = 1'b0;
        step();
        chk("hold_mid1",  w_sel, 7'b1000000);
        step();
        chk("hold_mid2",  w_sel, 7'b1000000);
        bact = 1'b0;
        step();
        chk("hold_end",   w_sel, 7'd0);

        // ---- RAM_BITS=21 window edges, compared with the 22-bit instance
        run_cycle(1'b0, 16'h2000, 1'b0);
        chk("rb21_200000",  w_sel21, 7'd0);
        chk("rb22_200000",  w_sel, 7'b1000010);
        run_cycle(1'b0, 16'h1FFF, 1'b1);
        chk("rb21_1FFF00",  w_sel21, 7'b1000000);
        chk("rb21_ovl",     {6'd0, bus21.Overlay}, 7'd0);
        run_cycle(1'b0, 16'h1FFD, 1'b0);
        chk("rb21_snoop",   w_sel21, {1'b1, 1'b0, SN, 1'b0, 1'b0, 1'b1, SN});
        chk("rb22_nosnoop", w_sel, 7'b1000010);

        // ---- reset in the middle of a ROM wait (count reaches 1)
        run_cycle(1'b1, 16'h8000, 1'b1);
        chk("rst_rom_sel",  w_sel, 7'b0110000);
        step();
        chk("rst_rom_rdy1", {6'd0, bus.ROMRDY}, 7'd0);
        RES = 1'b1;
        step();
        chk("rst_mid_sel",  w_sel, 7'd0);
        chk("rst_mid_sel21", w_sel21, 7'd0);
        chk("rst_mid_rdy_ovl", {5'd0, bus.ROMRDY, bus.Overlay}, 7'b0000001);
        RES = 1'b0; bact = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_after%0d", k),
                {w_sel[6:1], bus.ROMRDY}, 7'd0);
            chk($sformatf("rst_after_ovl%0d", k), {6'd0, bus.Overlay}, 7'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
